mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

Data-memory access sequencer that consumes the `MemRead`/`MemWrite` strobes produced by the MIPS control unit, together with the datapath's ALU address and store data. It drives a synchronous block RAM with configurable read latency. It stalls the datapath until load data is ready, and it flags illegal accesses. It sits between the datapath's MEM stage and the block memory.

## Interface
- `ADDR_WIDTH`, default 10: RAM word-address width (RAM depth = 2^ADDR_WIDTH words).
- `READ_LATENCY`, default 2: cycles from RAM enable to valid `ram_dout`. Legal range 1..4.

Ports:
- `CLK` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `MemRead` in 1: load request from the control unit.
- `MemWrite` in 1: store request from the control unit.
- `Addr` in 32: byte address from the ALU.
- `WriteData` in 32: store data.
- `ReadData` out 32: registered load result.
- `Stall` out 1: the datapath must hold state while this is high.
- `AddrError` out 1: the current request is illegal and has been dropped.
- `ram_en` out 1: RAM enable.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_WIDTH: RAM word address, equal to `Addr[ADDR_WIDTH+1:2]`.
- `ram_din` out 32: RAM write data.
- `ram_dout` in 32: RAM read data.

## Operation
- FSM states:
  - `IDLE`: the only state that accepts requests.
  - `READ_WAIT`: latency counter running.
  - `READ_DONE`: one-cycle result-present state.
- Request legality, evaluated in `IDLE` only:
  - Illegal if `Addr[1:0]` is not 0 (misaligned).
  - Illegal if `Addr[31:ADDR_WIDTH+2]` is not 0 (out of range).
  - Illegal if `MemRead` and `MemWrite` are both 1.
  - For an illegal request: `AddrError` is 1 in that cycle, there is no RAM access, `Stall` stays 0, and the FSM stays in `IDLE`.
- Legal write in `IDLE`:
  - `ram_en`=1, `ram_we`=1, `ram_din`=`WriteData`, `ram_addr` from `Addr`, all in the same cycle.
  - `Stall`=0 and the FSM stays in `IDLE`.
  - Back-to-back writes are accepted every cycle.
- Legal read in `IDLE`:
  - `ram_en`=1 and `ram_we`=0 in issue cycle T.
  - `Stall`=1 combinationally in T.
  - Latency counter loads READ_LATENCY-1 and the FSM goes to `READ_WAIT`.
  - If READ_LATENCY=1, the FSM goes straight to a capture cycle: `READ_WAIT` with the counter already at 0.
- `READ_WAIT`:
  - `Stall`=1, `ram_en`=0.
  - Counter decrements each cycle.
  - In the cycle the counter is 0 (cycle T+READ_LATENCY), `ReadData` is loaded from `ram_dout` at the clock edge and the FSM goes to `READ_DONE`.
- `READ_DONE`:
  - `Stall`=0, `ReadData` is valid, and request inputs are ignored; the datapath is advancing.
  - Next state is `IDLE`.
- `ReadData` holds its value until the next load capture. Writes do not alter it.
- RAM outputs are combinational from the FSM state and inputs. They are 0 in every state and cycle not listed above. `ram_addr`/`ram_din` are 0 when `ram_en`=0.
- Counter width is clog2(READ_LATENCY+1). It never wraps, because loading happens only in `IDLE`.

## Timing
- Reset values, held while `Reset`=0 regardless of other inputs:
  - `ReadData`=0, `Stall`=0, `AddrError`=0.
  - `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0.
  - State=`IDLE`, counter=0.
- Reset asserted mid-read: the pending read is abandoned, the FSM returns to `IDLE`, and `ReadData` clears to 0. There is no RAM access after reset release until a new request arrives.
- Load cost: `Stall` is high for READ_LATENCY+1 cycles (T through T+READ_LATENCY). `ReadData` is valid from cycle T+READ_LATENCY+1.
- Store cost: zero stall cycles.
- A write issued in cycle T followed by a read of the same word in any later `IDLE` cycle returns the written data. This relies on the RAM being synchronous; no forwarding is required.
- `AddrError` is combinational and asserted only in `IDLE`. It is never asserted in `READ_WAIT` or `READ_DONE`.

## Structure
- Shared package `mem_ctrl_pkg`:
  - state enum {`IDLE`, `READ_WAIT`, `READ_DONE`}.
  - `DATA_WIDTH`=32.
  - byte-offset width constant = 2.
- One sub-module, `latency_counter`: a loadable down-counter with a zero flag, parameterized by READ_LATENCY.
- Legality check and RAM drive logic stay in the top level.

## Test plan
- READ_LATENCY=2:
  - Write `Addr`=0x10, `WriteData`=0xDEADBEEF -> `ram_we`=1, `ram_addr`=4 in that cycle, `Stall`=0.
  - Then read `Addr`=0x10 -> `Stall` high for 3 cycles, then `ReadData`=0xDEADBEEF.
- `Addr`=0x13 with `MemRead`=1 -> `AddrError`=1 for one cycle, `ram_en`=0, `Stall`=0, `ReadData` unchanged.
- `Addr`=0x1000 with ADDR_WIDTH=10 (out of range), and separately `MemRead`=`MemWrite`=1 at 0x8 -> `AddrError`=1, no RAM access.
- Four consecutive writes to 0x0, 0x4, 0x8, 0xC -> four consecutive `ram_we` pulses, `Stall`=0 throughout.
- Pull `Reset` low one cycle after a read issue -> all outputs 0 immediately. After release, a read of 0x4 completes with normal latency and returns the stored value.
- READ_LATENCY=1 and READ_LATENCY=4: read-latency sweep -> `Stall` high for exactly 2 and 5 cycles respectively, with correct data.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access sequencer.
//   state_e        : sequencer FSM states
//   DATA_WIDTH     : datapath / RAM word width
//   BYTE_OFF_WIDTH : byte-offset bits below the word address
package mem_ctrl_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned BYTE_OFF_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    READ_DONE
  } state_e;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Bus bundle between the MEM stage, the sequencer and the block RAM.
//   Datapath side : MemRead, MemWrite, Addr, WriteData -> ReadData, Stall, AddrError
//   RAM side      : ram_en, ram_we, ram_addr, ram_din  <- ram_dout
// slave  : the sequencer's view (consumes requests, drives the RAM)
// master : the environment's view (datapath + RAM)
interface mem_access_sequencer_if
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
);

  logic                  MemRead;
  logic                  MemWrite;
  logic [DATA_WIDTH-1:0] Addr;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;
  logic                  Stall;
  logic                  AddrError;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData, ram_dout,
    output ReadData, Stall, AddrError, ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output MemRead, MemWrite, Addr, WriteData, ram_dout,
    input  ReadData, Stall, AddrError, ram_en, ram_we, ram_addr, ram_din
  );

endinterface

// File: rtl/latency_counter.sv
// Loadable down-counter tracking outstanding RAM read latency.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : load READ_LATENCY-1 (has priority over dec_i)
//   dec_i         : decrement, saturating at zero
//   zero_o        : counter is zero
module latency_counter #(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned CntWidth = $clog2(READ_LATENCY + 1);
  localparam logic [CntWidth-1:0] LoadVal = CntWidth'(READ_LATENCY - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_access_sequencer.sv
// MEM-stage sequencer between the MIPS datapath and a synchronous block RAM.
// Stores complete in the request cycle; loads stall the datapath for
// READ_LATENCY+1 cycles and the result is registered into ReadData.
// Illegal requests (misaligned, out of range, read+write) are dropped and
// flagged on AddrError.
//   CLK   : rising-edge clock
//   Reset : async active-low reset
//   bus   : datapath and RAM signals (slave modport)
module mem_access_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                          CLK,
  input  logic                          Reset,
  mem_access_sequencer_if.slave         bus
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;

  logic cnt_load, cnt_dec, cnt_zero;

  logic misaligned, out_of_range, conflict, illegal, rd_ok, wr_ok;

  logic                  stall;
  logic                  addr_error;
  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;

  always_comb begin
    misaligned   = |bus.Addr[BYTE_OFF_WIDTH-1:0];
    out_of_range = |bus.Addr[DATA_WIDTH-1:ADDR_WIDTH+BYTE_OFF_WIDTH];
    conflict     = bus.MemRead & bus.MemWrite;
    illegal      = (bus.MemRead | bus.MemWrite) & (misaligned | out_of_range | conflict);
    rd_ok        = bus.MemRead & ~illegal;
    wr_ok        = bus.MemWrite & ~illegal;
  end

  always_comb begin
    state_d     = state_q;
    read_data_d = read_data_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    stall       = 1'b0;
    addr_error  = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_din     = '0;
    unique case (state_q)
      IDLE: begin
        addr_error = illegal;
        if (wr_ok) begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = bus.Addr[ADDR_WIDTH+BYTE_OFF_WIDTH-1:BYTE_OFF_WIDTH];
          ram_din  = bus.WriteData;
        end else if (rd_ok) begin
          ram_en   = 1'b1;
          ram_addr = bus.Addr[ADDR_WIDTH+BYTE_OFF_WIDTH-1:BYTE_OFF_WIDTH];
          stall    = 1'b1;
          cnt_load = 1'b1;
          state_d  = READ_WAIT;
        end
      end
      READ_WAIT: begin
        stall = 1'b1;
        if (cnt_zero) begin
          read_data_d = bus.ram_dout;
          state_d     = READ_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      READ_DONE: begin
        // Datapath advances this cycle; any request it still shows is stale.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      read_data_q <= read_data_d;
    end
  end

  latency_counter #(
    .READ_LATENCY (READ_LATENCY)
  ) u_latency_counter (
    .clk_i  (CLK),
    .rst_ni (Reset),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  // Combinational outputs are forced low while reset is held, even though
  // the FSM sits in IDLE and would otherwise accept a request.
  assign bus.ReadData  = read_data_q;
  assign bus.Stall     = Reset & stall;
  assign bus.AddrError = Reset & addr_error;
  assign bus.ram_en    = Reset & ram_en;
  assign bus.ram_we    = Reset & ram_we;
  assign bus.ram_addr  = Reset ? ram_addr : '0;
  assign bus.ram_din   = Reset ? ram_din : '0;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench: three sequencers (READ_LATENCY 1, 2, 4) each with a
// behavioural synchronous RAM whose output is delayed by the latency.
module tb_mem_access_sequencer;

  localparam int unsigned AW = 10;
  localparam logic [31:0] Junk = 32'hBAD0_BAD0;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;
  int   n;

  mem_access_sequencer_if #(.ADDR_WIDTH(AW)) if_l1 ();
  mem_access_sequencer_if #(.ADDR_WIDTH(AW)) if_l2 ();
  mem_access_sequencer_if #(.ADDR_WIDTH(AW)) if_l4 ();

  mem_access_sequencer #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) u_l1 (
    .CLK(clk), .Reset(rst_n), .bus(if_l1)
  );
  mem_access_sequencer #(.ADDR_WIDTH(AW), .READ_LATENCY(2)) u_l2 (
    .CLK(clk), .Reset(rst_n), .bus(if_l2)
  );
  mem_access_sequencer #(.ADDR_WIDTH(AW), .READ_LATENCY(4)) u_l4 (
    .CLK(clk), .Reset(rst_n), .bus(if_l4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: read data appears READ_LATENCY cycles after the enable cycle,
  // junk otherwise so a mistimed capture shows up as wrong data.
  logic [31:0] mem1 [0:(1<<AW)-1];
  logic [31:0] mem2 [0:(1<<AW)-1];
  logic [31:0] mem4 [0:(1<<AW)-1];
  logic [31:0] pipe1 [0:0];
  logic [31:0] pipe2 [0:1];
  logic [31:0] pipe4 [0:3];

  always @(posedge clk) begin
    if (if_l1.ram_en && if_l1.ram_we) mem1[if_l1.ram_addr] <= if_l1.ram_din;
    pipe1[0] <= (if_l1.ram_en && !if_l1.ram_we) ? mem1[if_l1.ram_addr] : Junk;
  end
  always @(posedge clk) begin
    if (if_l2.ram_en && if_l2.ram_we) mem2[if_l2.ram_addr] <= if_l2.ram_din;
    pipe2[0] <= (if_l2.ram_en && !if_l2.ram_we) ? mem2[if_l2.ram_addr] : Junk;
    pipe2[1] <= pipe2[0];
  end
  always @(posedge clk) begin
    if (if_l4.ram_en && if_l4.ram_we) mem4[if_l4.ram_addr] <= if_l4.ram_din;
    pipe4[0] <= (if_l4.ram_en && !if_l4.ram_we) ? mem4[if_l4.ram_addr] : Junk;
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign if_l1.ram_dout = pipe1[0];
  assign if_l2.ram_dout = pipe2[1];
  assign if_l4.ram_dout = pipe4[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req2(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    if_l2.MemRead   = rd;
    if_l2.MemWrite  = wr;
    if_l2.Addr      = a;
    if_l2.WriteData = wd;
  endtask

  // Check every output of the latency-2 instance in one go.
  task automatic chk2(input string tag, input logic [31:0] rdata, input logic stall,
                      input logic aerr, input logic en, input logic we,
                      input logic [31:0] addr, input logic [31:0] din);
    chk({tag, ".ReadData"}, if_l2.ReadData, rdata);
    chk({tag, ".Stall"}, {31'd0, if_l2.Stall}, {31'd0, stall});
    chk({tag, ".AddrError"}, {31'd0, if_l2.AddrError}, {31'd0, aerr});
    chk({tag, ".ram_en"}, {31'd0, if_l2.ram_en}, {31'd0, en});
    chk({tag, ".ram_we"}, {31'd0, if_l2.ram_we}, {31'd0, we});
    chk({tag, ".ram_addr"}, 32'(if_l2.ram_addr), addr);
    chk({tag, ".ram_din"}, if_l2.ram_din, din);
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    if_l1.MemRead = 1'b0; if_l1.MemWrite = 1'b0; if_l1.Addr = '0; if_l1.WriteData = '0;
    if_l4.MemRead = 1'b0; if_l4.MemWrite = 1'b0; if_l4.Addr = '0; if_l4.WriteData = '0;
    // A legal write is presented during reset: nothing may reach the RAM.
    req2(1'b0, 1'b1, 32'h10, 32'h1234_5678);
    @(negedge clk); #2;
    chk2("rst_hold", 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    req2(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #2 chk2("post_rst", 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);

    // Store, then load the same word.
    @(negedge clk); req2(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    #2 chk2("wr10", 32'h0, 0, 0, 1, 1, 32'h4, 32'hDEAD_BEEF);
    @(negedge clk); req2(1'b1, 1'b0, 32'h10, 32'h0);
    #2 chk2("rd10_T", 32'h0, 1, 0, 1, 0, 32'h4, 32'h0);
    @(negedge clk); #2 chk2("rd10_T1", 32'h0, 1, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); #2 chk2("rd10_T2", 32'h0, 1, 0, 0, 0, 32'h0, 32'h0);
    // READ_DONE: request still asserted but ignored.
    @(negedge clk); #2 chk2("rd10_done", 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); req2(1'b0, 1'b0, 32'h0, 32'h0);
    #2 chk2("idle_hold", 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0, 32'h0);

    // Illegal requests.
    @(negedge clk); req2(1'b1, 1'b0, 32'h13, 32'h0);
    #2 chk2("misalign", 32'hDEAD_BEEF, 0, 1, 0, 0, 32'h0, 32'h0);
    @(negedge clk); req2(1'b0, 1'b0, 32'h13, 32'h0);
    #2 chk2("misalign_next", 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); req2(1'b1, 1'b0, 32'h1000, 32'h0);
    #2 chk2("oor_rd", 32'hDEAD_BEEF, 0, 1, 0, 0, 32'h0, 32'h0);
    @(negedge clk); req2(1'b0, 1'b1, 32'h8000_0000, 32'h5555_5555);
    #2 chk2("oor_wr", 32'hDEAD_BEEF, 0, 1, 0, 0, 32'h0, 32'h0);
    @(negedge clk); req2(1'b1, 1'b1, 32'h8, 32'h7777_7777);
    #2 chk2("rd_and_wr", 32'hDEAD_BEEF, 0, 1, 0, 0, 32'h0, 32'h0);
    // Highest legal word is in range.
    @(negedge clk); req2(1'b0, 1'b1, 32'hFFC, 32'hCAFE_F00D);
    #2 chk2("wr_top", 32'hDEAD_BEEF, 0, 0, 1, 1, 32'h3FF, 32'hCAFE_F00D);

    // Back-to-back stores.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req2(1'b0, 1'b1, 32'(i * 4), 32'h1111_0000 + 32'(i));
      #2 chk2($sformatf("b2b_wr%0d", i), 32'hDEAD_BEEF, 0, 0, 1, 1, 32'(i),
              32'h1111_0000 + 32'(i));
    end

    // Reset one cycle after a load issue.
    @(negedge clk); req2(1'b1, 1'b0, 32'h8, 32'h0);
    #2 chk2("rd8_T", 32'hDEAD_BEEF, 1, 0, 1, 0, 32'h2, 32'h0);
    @(negedge clk); rst_n = 1'b0;
    #2 chk2("rst_mid", 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); #2 chk2("rst_mid2", 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); req2(1'b0, 1'b0, 32'h0, 32'h0); rst_n = 1'b1;
    #2 chk2("rel_idle0", 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); #2 chk2("rel_idle1", 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); #2 chk2("rel_idle2", 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clk); req2(1'b1, 1'b0, 32'h4, 32'h0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (!if_l2.Stall) break;
      n++;
      @(negedge clk);
    end
    req2(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rd4_stall_cycles", 32'(n), 32'd3);
    chk("rd4_data", if_l2.ReadData, 32'h1111_0001);
    // Readback of the top word confirms the store landed.
    @(negedge clk); req2(1'b1, 1'b0, 32'hFFC, 32'h0);
    repeat (3) @(negedge clk);
    req2(1'b0, 1'b0, 32'h0, 32'h0);
    #2 chk("rdtop_data", if_l2.ReadData, 32'hCAFE_F00D);

    // Latency 1 sweep.
    @(negedge clk);
    if_l1.MemWrite = 1'b1; if_l1.Addr = 32'h20; if_l1.WriteData = 32'hA5A5_0001;
    #2 chk("l1_wr_we", {31'd0, if_l1.ram_we}, 32'd1);
    chk("l1_wr_stall", {31'd0, if_l1.Stall}, 32'd0);
    @(negedge clk);
    if_l1.MemWrite = 1'b0; if_l1.MemRead = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (!if_l1.Stall) break;
      n++;
      @(negedge clk);
    end
    if_l1.MemRead = 1'b0;
    chk("l1_stall_cycles", 32'(n), 32'd2);
    chk("l1_data", if_l1.ReadData, 32'hA5A5_0001);

    // Latency 4 sweep.
    @(negedge clk);
    if_l4.MemWrite = 1'b1; if_l4.Addr = 32'h3C; if_l4.WriteData = 32'h5A5A_0004;
    #2 chk("l4_wr_we", {31'd0, if_l4.ram_we}, 32'd1);
    @(negedge clk);
    if_l4.MemWrite = 1'b0; if_l4.MemRead = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (!if_l4.Stall) break;
      n++;
      @(negedge clk);
    end
    if_l4.MemRead = 1'b0;
    chk("l4_stall_cycles", 32'(n), 32'd5);
    chk("l4_data", if_l4.ReadData, 32'h5A5A_0004);
    chk("l4_done_aerr", {31'd0, if_l4.AddrError}, 32'd0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
